// File: rtl/coin_input_conditioner_if.sv
// Coin bus between the button conditioner and the vending FSM.
// total_rs exists only when COIN_TOTAL_EN is defined.
interface coin_input_conditioner_if;
  logic       btn5_raw;
  logic       btn10_raw;
  logic [1:0] coin_code;
  logic       coin_valid;
  logic       busy;
  logic       reject;
`ifdef COIN_TOTAL_EN
  logic [7:0] total_rs;

  modport master (
    input  btn5_raw, btn10_raw,
    output coin_code, coin_valid,
    output busy, reject, total_rs
  );

  modport slave (
    output btn5_raw, btn10_raw,
    input  coin_code, coin_valid,
    input  busy, reject, total_rs
  );
`else
  modport master (
    input  btn5_raw, btn10_raw,
    output coin_code, coin_valid,
    output busy, reject
  );

  modport slave (
    output btn5_raw, btn10_raw,
    input  coin_code, coin_valid,
    input  busy, reject
  );
`endif
endinterface

// File: rtl/coin_input_conditioner.sv
// Sync, debounce and edge-detect two coin buttons into one-shot codes.
// Optional COIN_TOTAL_EN adds a saturating running total (total_rs).
module coin_input_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 3,
  parameter int LOCKOUT     = 2
) (
  input logic                       u_clk,
  input logic                       rst,
  coin_input_conditioner_if.master  bus
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int LW = $clog2(LOCKOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    LOCK,
    WAIT_REL
  } state_t;

  logic [1:0] raw;
  logic [1:0] lvl;
  logic [1:0] press;

  assign raw = {bus.btn10_raw, bus.btn5_raw};

  // bit 0 = 5 Rs, bit 1 = 10 Rs, matching the coin code bits
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DW-1:0]          cnt_q, cnt_d;
    logic                   lvl_q, lvl_d;
    logic                   prev_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      if (synced != lvl_q) begin
        if (cnt_q == DW'(DEBOUNCE - 1))
          lvl_d = synced;
        else
          cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge u_clk) begin
      if (rst) begin
        sync_q <= '0;
        cnt_q  <= '0;
        lvl_q  <= 1'b0;
        prev_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw[b]};
        cnt_q  <= cnt_d;
        lvl_q  <= lvl_d;
        prev_q <= lvl_q;
      end
    end

    assign lvl[b]   = lvl_q;
    assign press[b] = lvl_q & ~prev_q;
  end

  state_t      state_q, state_d;
  logic [1:0]  code_q, code_d;
  logic [LW-1:0] lock_q, lock_d;
  logic [1:0]  coin_code_q, coin_code_d;
  logic        coin_valid_q, coin_valid_d;
  logic        busy_q, busy_d;
  logic        reject_q, reject_d;

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    lock_d   = lock_q;
    reject_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (&press) begin
          reject_d = 1'b1;
          state_d  = WAIT_REL;
        end else if (|press) begin
          code_d  = press;
          state_d = EMIT;
        end
      end
      EMIT: begin
        lock_d  = LW'(LOCKOUT);
        state_d = LOCK;
      end
      LOCK: begin
        lock_d = lock_q - 1'b1;
        if (lock_q <= LW'(1))
          state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (~|lvl)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // outputs are registered from the next state
    coin_valid_d = (state_d == EMIT);
    coin_code_d  = coin_valid_d ? code_d : 2'b00;
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge u_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      code_q       <= 2'b00;
      lock_q       <= '0;
      coin_code_q  <= 2'b00;
      coin_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      reject_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      lock_q       <= lock_d;
      coin_code_q  <= coin_code_d;
      coin_valid_q <= coin_valid_d;
      busy_q       <= busy_d;
      reject_q     <= reject_d;
    end
  end

  assign bus.coin_code  = coin_code_q;
  assign bus.coin_valid = coin_valid_q;
  assign bus.busy       = busy_q;
  assign bus.reject     = reject_q;

`ifdef COIN_TOTAL_EN
  logic [7:0] total_q, total_d;
  logic [8:0] sum;

  always_comb begin
    sum     = {1'b0, total_q} + ((code_d == 2'b01) ? 9'd5 : 9'd10);
    total_d = total_q;
    if (state_q == IDLE && state_d == EMIT)
      total_d = (sum > 9'd250) ? 8'd250 : sum[7:0];
  end

  always_ff @(posedge u_clk) begin
    if (rst)
      total_q <= 8'd0;
    else
      total_q <= total_d;
  end

  assign bus.total_rs = total_q;
`endif

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Randomised scoreboard bench for coin_input_conditioner.
// Build with +define+COIN_TOTAL_EN to exercise the running total.
module tb_coin_input_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 3;
  localparam int LOCK = 2;
  localparam int LAT  = SYNC + DEB + 1;

  logic u_clk = 1'b0;
  logic rst   = 1'b1;

  coin_input_conditioner_if bus();

  coin_input_conditioner #(
    .SYNC_STAGES(SYNC),
    .DEBOUNCE(DEB),
    .LOCKOUT(LOCK)
  ) dut (
    .u_clk(u_clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 u_clk = ~u_clk;

  int cyc = 0;
  always @(posedge u_clk) cyc <= cyc + 1;

  typedef struct {
    int         t;
    logic [1:0] code;
    bit         rej;
  } exp_t;

  exp_t sb[$];
  int nvec = 0;
  int nerr = 0;
`ifdef COIN_TOTAL_EN
  int exp_total = 0;
`endif

  task automatic check(input string name, input int act, input int req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d (cyc %0d)",
               name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge u_clk);
  endtask

  task automatic expect_out(input int t, input logic [1:0] code,
                            input bit rej);
    exp_t e;
    e.t = t;
    e.code = code;
    e.rej = rej;
    sb.push_back(e);
  endtask

  always @(negedge u_clk) begin
    exp_t e;
    check("code_not_11", int'(bus.coin_code == 2'b11), 0);
    check("valid_vs_code", int'(bus.coin_valid),
          int'(bus.coin_code != 2'b00));
    if (bus.coin_valid || bus.reject) begin
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_out: got code %0d rej %0d, want none (cyc %0d)",
                 bus.coin_code, bus.reject, cyc);
      end else begin
        e = sb.pop_front();
        check("out_time", cyc, e.t);
        check("out_code", int'(bus.coin_code), int'(e.code));
        check("out_reject", int'(bus.reject), int'(e.rej));
`ifdef COIN_TOTAL_EN
        if (!e.rej) begin
          exp_total += (e.code == 2'b01) ? 5 : 10;
          if (exp_total > 250) exp_total = 250;
          check("total_rs", int'(bus.total_rs), exp_total);
        end
`endif
      end
    end
  end

  // short runs never reach DEBOUNCE samples, so no level change
  task automatic bounce(input bit b5, input bit b10);
    int n;
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      bus.btn5_raw  = b5;
      bus.btn10_raw = b10;
      tick($urandom_range(1, DEB - 1));
      bus.btn5_raw  = 1'b0;
      bus.btn10_raw = 1'b0;
      tick($urandom_range(1, 3));
    end
  endtask

  task automatic episode(input int kind);
    int k;
    int j;
    check("idle_not_busy", int'(bus.busy), 0);
    case (kind)
      0, 1: begin
        bounce(kind == 0, kind == 1);
        bus.btn5_raw  = (kind == 0);
        bus.btn10_raw = (kind == 1);
        k = cyc;
        expect_out(k + LAT, (kind == 0) ? 2'b01 : 2'b10, 1'b0);
        tick(LAT + 2);
        check("busy_held", int'(bus.busy), 1);
        tick($urandom_range(4, 10));
        bus.btn5_raw  = 1'b0;
        bus.btn10_raw = 1'b0;
      end
      2: begin
        bounce(1'b1, 1'b1);
        bus.btn5_raw  = 1'b1;
        bus.btn10_raw = 1'b1;
        k = cyc;
        expect_out(k + LAT, 2'b00, 1'b1);
        tick(LAT + 4);
        bus.btn5_raw = 1'b0;
        tick(10);
        check("wait_one_held", int'(bus.busy), 1);
        bus.btn10_raw = 1'b0;
      end
      default: begin
        bounce(1'b1, 1'b0);
        bus.btn5_raw = 1'b1;
        k = cyc;
        expect_out(k + LAT, 2'b01, 1'b0);
        j = $urandom_range(1, 8);
        tick(j);
        bus.btn10_raw = 1'b1;
        tick(LAT + 12);
        bus.btn5_raw  = 1'b0;
        bus.btn10_raw = 1'b0;
      end
    endcase
    tick(12);
  endtask

  initial begin
    int k;
    bus.btn5_raw  = 1'b0;
    bus.btn10_raw = 1'b0;
    rst = 1'b1;
    tick(3);
    check("rst_code", int'(bus.coin_code), 0);
    check("rst_valid", int'(bus.coin_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_reject", int'(bus.reject), 0);
`ifdef COIN_TOTAL_EN
    check("rst_total", int'(bus.total_rs), 0);
`endif
    rst = 1'b0;
    tick(2);

    episode(0);

    for (int i = 0; i < 4; i++) begin
      bus.btn10_raw = i[0] ? 1'b0 : 1'b1;
      tick(1);
    end
    bus.btn10_raw = 1'b1;
    k = cyc;
    expect_out(k + LAT, 2'b10, 1'b0);
    tick(LAT + 4);
    bus.btn10_raw = 1'b0;
    tick(12);

    episode(2);
    episode(3);

    // reset lands on the EMIT cycle
    bus.btn5_raw = 1'b1;
    k = cyc;
    expect_out(k + LAT, 2'b01, 1'b0);
    tick(LAT);
    rst = 1'b1;
    bus.btn5_raw = 1'b0;
    tick(1);
    check("rst_emit_code", int'(bus.coin_code), 0);
    check("rst_emit_valid", int'(bus.coin_valid), 0);
`ifdef COIN_TOTAL_EN
    check("rst_emit_total", int'(bus.total_rs), 0);
    exp_total = 0;
`endif
    tick(1);
    rst = 1'b0;
    tick(15);

    // button held through reset release
    bus.btn10_raw = 1'b1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    k = cyc;
    expect_out(k + LAT, 2'b10, 1'b0);
    tick(LAT + 4);
    bus.btn10_raw = 1'b0;
    tick(12);

    for (int i = 0; i < 40; i++)
      episode($urandom_range(0, 3));

`ifdef COIN_TOTAL_EN
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    exp_total = 0;
    tick(2);
    for (int i = 0; i < 26; i++)
      episode(1);
    check("total_sat10", int'(bus.total_rs), 250);
    episode(0);
    check("total_sat5", int'(bus.total_rs), 250);
`endif

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
